// File: rtl/adc_avg_pkg.sv
// Shared defaults and controller state type for the ADC channel averager.
// Optional rounding is selected in the top with ADC_AVG_ROUND_EN.
package adc_avg_pkg;

    localparam int DEF_DATA_W   = 12;
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_CH_W     = 2;
    localparam int DEF_LOG2_AVG = 3;
    localparam int ACC_W        = DEF_DATA_W + DEF_LOG2_AVG;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT,
        HOLD
    } avg_state_t;

endpackage

// File: rtl/adc_acc_bank.sv
// Per-channel accumulator and sample-count register file with one
// read-modify-write port and a completion look-ahead for the next sample.
module adc_acc_bank
    import adc_avg_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CH_W     = DEF_CH_W,
    parameter int LOG2_AVG = DEF_LOG2_AVG
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       upd,
    input  logic [CH_W-1:0]            upd_ch,
    input  logic [DATA_W-1:0]          upd_data,
    output logic [DATA_W+LOG2_AVG-1:0] sum,
    output logic                       complete,
    input  logic [CH_W-1:0]            peek_ch,
    output logic                       peek_complete
);

    localparam int AW = DATA_W + LOG2_AVG;
    localparam logic [LOG2_AVG-1:0] LAST = '1;

    logic [AW-1:0]       acc [NUM_CH];
    logic [LOG2_AVG-1:0] cnt [NUM_CH];

    assign sum      = acc[upd_ch] + AW'(upd_data);
    assign complete = cnt[upd_ch] == LAST;

    // The peeked channel may be the one being updated this cycle.
    always_comb begin
        peek_complete = cnt[peek_ch] == LAST;
        if (upd && (upd_ch == peek_ch))
            peek_complete = !complete && (cnt[upd_ch] == LAST - 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (upd) begin
            if (complete) begin
                acc[upd_ch] <= '0;
                cnt[upd_ch] <= '0;
            end else begin
                acc[upd_ch] <= sum;
                cnt[upd_ch] <= cnt[upd_ch] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel boxcar averager behind the ADC SPI controller.
// Define ADC_AVG_ROUND_EN for round-half-up results instead of truncation.
module adc_channel_averager
    import adc_avg_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CH_W     = DEF_CH_W,
    parameter int LOG2_AVG = DEF_LOG2_AVG
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data,
    output logic              overrun
);

    localparam int AW = DATA_W + LOG2_AVG;
    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);
`ifdef ADC_AVG_ROUND_EN
    localparam logic [AW-1:0] RND = AW'(1) << (LOG2_AVG - 1);
`else
    localparam logic [AW-1:0] RND = '0;
`endif

    avg_state_t        state;
    avg_state_t        state_nxt;
    logic [CH_W-1:0]   s1_ch;
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;
    logic              s1_done;
    logic              bank_done;
    logic              peek_done;
    logic              in_range;
    logic              accept;
    logic              load;
    logic              ov_nxt;
    logic [AW-1:0]     sum;
    logic [AW-1:0]     rnd_sum;

    assign in_range = {1'b0, in_ch} < CH_LIM;
    assign s1_valid = (state == ACCUM) || (state == EMIT);
    assign s1_done  = state == EMIT;
    assign in_ready = !(s1_done || (out_valid && !out_ready));
    assign accept   = in_valid && in_ready && in_range && !clear;
    assign load     = s1_valid && bank_done;
    assign rnd_sum  = sum + RND;

    adc_acc_bank #(
        .DATA_W   (DATA_W),
        .NUM_CH   (NUM_CH),
        .CH_W     (CH_W),
        .LOG2_AVG (LOG2_AVG)
    ) u_bank (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .upd           (s1_valid),
        .upd_ch        (s1_ch),
        .upd_data      (s1_data),
        .sum           (sum),
        .complete      (bank_done),
        .peek_ch       (in_ch),
        .peek_complete (peek_done)
    );

    // A reload from S2 beats a same-cycle transfer; clear beats both.
    always_comb begin
        ov_nxt    = out_valid;
        state_nxt = IDLE;
        if (out_valid && out_ready)
            ov_nxt = 1'b0;
        if (load)
            ov_nxt = 1'b1;
        if (clear)
            ov_nxt = 1'b0;
        if (clear)
            state_nxt = IDLE;
        else if (accept)
            state_nxt = peek_done ? EMIT : ACCUM;
        else if (ov_nxt)
            state_nxt = HOLD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_ch   <= '0;
            s1_data <= '0;
        end else if (accept) begin
            s1_ch   <= in_ch;
            s1_data <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= ov_nxt;
            if (load && !clear) begin
                out_ch   <= s1_ch;
                out_data <= rnd_sum[AW-1 -: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overrun <= 1'b0;
        else if (clear)
            overrun <= 1'b0;
        else if (in_valid && !in_ready && in_range)
            overrun <= 1'b1;
    end

endmodule

// File: doc/adc_channel_averager.md
Name: adc_channel_averager

Overview:
- Sits directly downstream of the ADC SPI controller.
- Consumes one 12-bit conversion result per in_valid pulse, tagged with its channel number.
- Keeps a separate boxcar average per channel over 2^LOG2_AVG samples and emits one averaged word per completed block through a valid/ready output.
- Decouples noisy raw samples from display and control logic.

Parameters:
DATA_W, 12, sample and result width
NUM_CH, 4, channels averaged (1..2^CH_W)
CH_W, 2, channel tag width
LOG2_AVG, 3, log2 of samples per average (1..8)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of all accumulators, pipeline and flags
in_valid  in  1  one-cycle strobe: in_ch/in_data hold a new sample
in_ch  in  CH_W  channel of sample
in_data  in  DATA_W  raw ADC sample
in_ready  out  1  high = sample presented this cycle will be accepted
out_valid  out  1  averaged result available
out_ready  in  1  consumer accepts result
out_ch  out  CH_W  channel of result
out_data  out  DATA_W  averaged value
overrun  out  1  sticky: a valid sample was dropped

Behaviour:
- Reset: clk single domain; reset_n asynchronous, active-low. On reset all accumulators, counts, s1 stage, out_valid, out_ch, out_data and overrun are 0; in_ready is 1.
- Per channel state:
  - acc[ch], width DATA_W+LOG2_AVG, unsigned.
  - cnt[ch], width LOG2_AVG.
- Pipeline stage S1: registers in_ch/in_data when in_valid && in_ready && in_ch < NUM_CH.
- Stage S2, the cycle after S1:
  - sum = acc[ch] + sample.
  - If cnt[ch] == 2^LOG2_AVG-1: load out_data = sum >> LOG2_AVG (truncate), load out_ch = ch, set out_valid, set acc[ch] = 0 and cnt[ch] = 0.
  - Otherwise: acc[ch] = sum, cnt[ch] += 1.
- Latency: the completing sample accepted in cycle t gives out_valid=1 in cycle t+2.
- Output handshake:
  - out_valid, out_ch and out_data stay stable until out_valid && out_ready; out_valid then clears next cycle unless S2 reloads the output in the same cycle, in which case the reload wins.
  - A transfer and a reload in the same cycle are legal.
- in_ready = !((s1_valid && s1 completes its block) || (out_valid && !out_ready)).
- Dropped samples:
  - in_valid while in_ready=0: sample dropped, overrun set (sticky until clear or reset).
  - Upstream cannot stall, so in_ready is advisory only.
- in_ch >= NUM_CH: sample silently discarded; no state change, overrun unaffected.
- Controller FSM: states IDLE (s1 empty), ACCUM (s1 holds non-completing sample), EMIT (s1 holds completing sample), HOLD (out_valid && !out_ready, no s1). Transitions follow the rules above; the state is exposed for debug only via the package type.
- clear: has priority over everything in the same cycle.
  - Zeroes acc and cnt, empties s1, drops out_valid, clears overrun.
  - An in_valid in the same cycle is discarded without setting overrun.
- Width rule: the max sum plus rounding offset (32764 at defaults) fits DATA_W+LOG2_AVG bits, so no saturation logic is needed.

Optional Feature:
- Macro ADC_AVG_ROUND_EN.
- Defined: result = (sum + 2^(LOG2_AVG-1)) >> LOG2_AVG (round half up).
- Undefined: plain truncation.
- Interface is identical either way.

Decomposition:
- Package adc_avg_pkg:
  - default DATA_W/CH_W/NUM_CH/LOG2_AVG localparams
  - ACC_W = DATA_W+LOG2_AVG
  - averager FSM state enum
- Sub-module adc_acc_bank: NUM_CH-entry accumulator/count register file with one read-modify-write port, a completion flag and a clear input.
- Top module holds S1, the FSM, the output register and overrun.

Test Plan:
- Reset, then ch0 samples 100..107 on successive in_valid: out_valid two cycles after the 8th sample; out_ch=0, out_data=103 (104 with ADC_AVG_ROUND_EN); no earlier out_valid.
- Round-robin ch0..3 with constant values 10/20/30/40 for 8 rounds, out_ready=1: exactly four results, in order ch0..ch3, values 10, 20, 30, 40; overrun=0.
- Eight 4095 samples on ch1: out_data=4095 in both builds, with no wrap.
- Hold out_ready=0 after a result, then complete ch2 and send one more ch3 sample: in_ready=0, overrun=1; the first result is unchanged until out_ready=1.
- Four ch2 samples of 900, pulse clear together with an in_valid, then eight samples of 50: a single result ch2=50; overrun=0.
- Assert reset_n=0 mid-block with out_valid=1: out_valid, out_data and overrun drop immediately (asynchronously); after release, a new 8-sample block averages correctly from zero.
